// File: rtl/window_scan_pkg.sv
// Shared state encoding, default geometry and delay-line entry type
// for the 3x3 window scan sequencer.
package window_scan_pkg;

    localparam int unsigned IMG_W_DEF    = 256;
    localparam int unsigned IMG_H_DEF    = 256;
    localparam int unsigned AW_DEF       = 8;
    localparam int unsigned DW_DEF       = 8;
    localparam int unsigned PIPE_LAT_DEF = 3;

    // Position width carried through the delay line; the top's AW must equal it.
    localparam int unsigned POS_W = AW_DEF;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SCAN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
    } dl_entry_t;

endpackage

// File: rtl/window_scan_ctrl_delay_line.sv
// Fixed-latency shift register that follows each issued window read
// through the filter pipeline so its write-back can be issued on time.
module scan_delay_line
    import window_scan_pkg::*;
#(
    parameter int unsigned DEPTH = PIPE_LAT_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr_i,
    input  dl_entry_t push_i,
    output dl_entry_t pop_o,
    output logic      any_valid_o
);

    dl_entry_t [DEPTH-1:0] stage_q;
    logic                  any_valid_q;
    logic                  any_valid_d;

    // Occupancy after the next shift: the incoming entry plus all but the oldest stage.
    always_comb begin
        any_valid_d = push_i.valid;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            any_valid_d = any_valid_d | stage_q[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q     <= '0;
            any_valid_q <= 1'b0;
        end else if (clr_i) begin
            stage_q     <= '0;
            any_valid_q <= 1'b0;
        end else begin
            stage_q     <= {stage_q[DEPTH-2:0], push_i};
            any_valid_q <= any_valid_d;
        end
    end

    assign pop_o       = stage_q[DEPTH-1];
    assign any_valid_o = any_valid_q;

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer: issues one window read per cycle and writes each
// filtered result back PIPE_LAT+1 cycles later.
module window_scan_ctrl
    import window_scan_pkg::*;
#(
    parameter int unsigned IMG_W    = IMG_W_DEF,
    parameter int unsigned IMG_H    = IMG_H_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    input  logic          abort,
    input  logic [DW-1:0] filt_pixel,
    output logic          rd,
    output logic [AW-1:0] addr_row_r,
    output logic [AW-1:0] addr_col_r,
    output logic          wr,
    output logic [AW-1:0] addr_row_w,
    output logic [AW-1:0] addr_col_w,
    output logic [DW-1:0] cl_pixel,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 1);

    logic [ST_W-1:0] state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [AW-1:0]   col_q, col_d;
    logic            rd_q, rd_d;
    logic [AW-1:0]   ar_row_q, ar_row_d;
    logic [AW-1:0]   ar_col_q, ar_col_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   aw_row_q, aw_row_d;
    logic [AW-1:0]   aw_col_q, aw_col_d;
    logic [DW-1:0]   pix_q, pix_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    dl_entry_t dl_push;
    dl_entry_t dl_pop;
    logic      dl_any_valid;
    logic      dl_clr;

    // Every presented read enters the delay line; idle cycles push bubbles.
    always_comb begin
        dl_push       = '0;
        dl_push.valid = rd_q;
        dl_push.row   = POS_W'(ar_row_q);
        dl_push.col   = POS_W'(ar_col_q);
    end

    scan_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay_line (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (dl_clr),
        .push_i      (dl_push),
        .pop_o       (dl_pop),
        .any_valid_o (dl_any_valid)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        rd_d     = 1'b0;
        ar_row_d = ar_row_q;
        ar_col_d = ar_col_q;
        wr_d     = 1'b0;
        aw_row_d = aw_row_q;
        aw_col_d = aw_col_q;
        pix_d    = pix_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        dl_clr   = 1'b0;

        // Write-back runs independently of the scan state.
        if (dl_pop.valid) begin
            wr_d     = 1'b1;
            aw_row_d = AW'(dl_pop.row);
            aw_col_d = AW'(dl_pop.col);
            pix_d    = filt_pixel;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SCAN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_SCAN: begin
                if (!hold) begin
                    rd_d     = 1'b1;
                    ar_row_d = row_q;
                    ar_col_d = col_q;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + AW'(1);
                        end
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // rd_q covers the final read that has not yet entered the delay line.
                if (!dl_any_valid && !rd_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            row_d    = '0;
            col_d    = '0;
            rd_d     = 1'b0;
            ar_row_d = ar_row_q;
            ar_col_d = ar_col_q;
            wr_d     = 1'b0;
            aw_row_d = aw_row_q;
            aw_col_d = aw_col_q;
            pix_d    = pix_q;
            dl_clr   = 1'b1;
        end

        busy_d = (state_d == ST_SCAN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            rd_q     <= 1'b0;
            ar_row_q <= '0;
            ar_col_q <= '0;
            wr_q     <= 1'b0;
            aw_row_q <= '0;
            aw_col_q <= '0;
            pix_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rd_q     <= rd_d;
            ar_row_q <= ar_row_d;
            ar_col_q <= ar_col_d;
            wr_q     <= wr_d;
            aw_row_q <= aw_row_d;
            aw_col_q <= aw_col_d;
            pix_q    <= pix_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rd         = rd_q;
    assign addr_row_r = ar_row_q;
    assign addr_col_r = ar_col_q;
    assign wr         = wr_q;
    assign addr_row_w = aw_row_q;
    assign addr_col_w = aw_col_q;
    assign cl_pixel   = pix_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Randomized bench for window_scan_ctrl on a 4x3 image against a
// cycle-indexed schedule of expected reads, writes, busy and done.
module tb_window_scan_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned LAT  = 3;
    localparam int          NPIX = int'(W * H);
    localparam int          MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] filt_pixel = '0;
    logic          rd, wr, busy, done;
    logic [AW-1:0] addr_row_r, addr_col_r, addr_row_w, addr_col_w;
    logic [DW-1:0] cl_pixel;

    always #5 clk = ~clk;

    window_scan_ctrl #(
        .IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW), .PIPE_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
        .filt_pixel(filt_pixel),
        .rd(rd), .addr_row_r(addr_row_r), .addr_col_r(addr_col_r),
        .wr(wr), .addr_row_w(addr_row_w), .addr_col_w(addr_col_w),
        .cl_pixel(cl_pixel), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected schedule, indexed by cycle number.
    bit            exp_rd   [MAXC];
    int            exp_rrow [MAXC];
    int            exp_rcol [MAXC];
    bit            exp_wv   [MAXC];
    int            exp_wrow [MAXC];
    int            exp_wcol [MAXC];
    int            exp_wsrc [MAXC];
    logic [DW-1:0] filt_hist[MAXC];

    bit            m_active   = 1'b0;
    bit            m_scanning = 1'b0;
    int            m_issued   = 0;
    int            m_begin    = 0;
    int            m_busy_until = -1;
    int            m_done_cyc = -1;
    int            last_rrow = 0, last_rcol = 0, last_wrow = 0, last_wcol = 0;
    logic [DW-1:0] last_pix = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit busy_exp(input int c);
        return m_active && (c >= m_begin) && (c <= m_busy_until);
    endfunction

    function automatic bit model_idle(input int c);
        return !busy_exp(c) && (c != m_done_cyc);
    endfunction

    task automatic check_outputs();
        if (exp_rd[cyc]) begin
            last_rrow = exp_rrow[cyc];
            last_rcol = exp_rcol[cyc];
        end
        if (exp_wv[cyc]) begin
            last_wrow = exp_wrow[cyc];
            last_wcol = exp_wcol[cyc];
            last_pix  = filt_hist[exp_wsrc[cyc]];
        end
        check_eq("rd",       32'(rd),         32'(exp_rd[cyc]));
        check_eq("row_r",    32'(addr_row_r), 32'(last_rrow));
        check_eq("col_r",    32'(addr_col_r), 32'(last_rcol));
        check_eq("wr",       32'(wr),         32'(exp_wv[cyc]));
        check_eq("row_w",    32'(addr_row_w), 32'(last_wrow));
        check_eq("col_w",    32'(addr_col_w), 32'(last_wcol));
        check_eq("cl_pixel", 32'(cl_pixel),   32'(last_pix));
        check_eq("busy",     32'(busy),       32'(busy_exp(cyc)));
        check_eq("done",     32'(done),       32'(cyc == m_done_cyc));
    endtask

    // Effect of inputs driven in cycle c on cycle c+1 and later.
    task automatic model_step(input bit s, input bit h, input bit a);
        int  c;
        bit  idle;
        c    = cyc;
        idle = model_idle(c);
        if (a && !idle) begin
            m_active     = 1'b0;
            m_scanning   = 1'b0;
            m_issued     = 0;
            m_busy_until = c;
            m_done_cyc   = -1;
            for (int k = c + 1; k <= c + int'(LAT) + 4; k++) exp_wv[k] = 1'b0;
        end
        exp_rd[c+1] = 1'b0;
        if (m_scanning && !h) begin
            exp_rd[c+1]   = 1'b1;
            exp_rrow[c+1] = m_issued / int'(W);
            exp_rcol[c+1] = m_issued % int'(W);
            exp_wv[c+int'(LAT)+2]   = 1'b1;
            exp_wrow[c+int'(LAT)+2] = m_issued / int'(W);
            exp_wcol[c+int'(LAT)+2] = m_issued % int'(W);
            exp_wsrc[c+int'(LAT)+2] = c + int'(LAT) + 1;
            m_issued++;
            if (m_issued == NPIX) begin
                m_scanning   = 1'b0;
                m_busy_until = c + int'(LAT) + 2;
                m_done_cyc   = c + int'(LAT) + 3;
            end
        end
        if (idle && s && !a) begin
            m_active     = 1'b1;
            m_scanning   = 1'b1;
            m_issued     = 0;
            m_begin      = c + 1;
            m_busy_until = 2 * MAXC;
            m_done_cyc   = -1;
        end
    endtask

    task automatic step(input bit s, input bit h, input bit a);
        if (cyc > MAXC - 16) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 16);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
        check_outputs();
        start      = s;
        hold       = h;
        abort      = a;
        filt_pixel = DW'($urandom);
        filt_hist[cyc] = filt_pixel;
        model_step(s, h, a);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        rst   = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        #1;
        check_eq("rst_rd",    32'(rd),         32'd0);
        check_eq("rst_wr",    32'(wr),         32'd0);
        check_eq("rst_busy",  32'(busy),       32'd0);
        check_eq("rst_done",  32'(done),       32'd0);
        check_eq("rst_row_r", 32'(addr_row_r), 32'd0);
        check_eq("rst_col_r", 32'(addr_col_r), 32'd0);
        check_eq("rst_row_w", 32'(addr_row_w), 32'd0);
        check_eq("rst_col_w", 32'(addr_col_w), 32'd0);
        check_eq("rst_pixel", 32'(cl_pixel),   32'd0);
        m_active     = 1'b0;
        m_scanning   = 1'b0;
        m_issued     = 0;
        m_busy_until = -1;
        m_done_cyc   = -1;
        last_rrow = 0; last_rcol = 0; last_wrow = 0; last_wcol = 0; last_pix = '0;
        for (int k = cyc; k <= cyc + int'(LAT) + 8; k++) begin
            exp_wv[k] = 1'b0;
            exp_rd[k] = 1'b0;
        end
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        repeat (2) step(0, 0, 0);

        // Plain unheld scan.
        step(1, 0, 0);
        repeat (25) step(0, 0, 0);

        // Hold for 5 cycles right after (1,1) has been issued.
        step(1, 0, 0);
        for (int i = 0; i < 40 && m_issued < 6; i++) step(0, 0, 0);
        repeat (5) step(0, 1, 0);
        repeat (25) step(0, 0, 0);

        // Abort two cycles after the read of (2,0), then rescan.
        step(1, 0, 0);
        for (int i = 0; i < 40 && m_issued < 9; i++) step(0, 0, 0);
        repeat (2) step(0, 0, 0);
        step(0, 0, 1);
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);
        repeat (25) step(0, 0, 0);

        // Start pulses during SCAN and during DONE are ignored.
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 60 && cyc != m_done_cyc; i++) step(0, 0, 0);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);

        // Reset while draining.
        step(1, 0, 0);
        for (int i = 0; i < 40 && m_issued < NPIX; i++) step(0, 0, 0);
        step(0, 0, 0);
        do_reset();
        repeat (8) step(0, 0, 0);

        // Random start/hold/abort traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 40) == 0);
        end
        repeat (25) step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
